// File: rtl/plic_pkg.sv
// ---------------------------------------------------------------------------
// plic_pkg
// Shared definitions for the PLIC target controller:
//   - default sizes (number of sources, priority width, decoded address width)
//   - byte offsets of the register map
//   - prio_t priority type and reg_sel_e register-select enum
// ---------------------------------------------------------------------------
package plic_pkg;

    localparam int N_SRC_DEFAULT  = 6;
    localparam int PRIO_W_DEFAULT = 3;
    localparam int ADDR_W_DEFAULT = 10;

    // Byte offsets inside the block's address window
    localparam int unsigned PRIO_BASE = 'h000;
    localparam int unsigned PEND_OFS  = 'h080;
    localparam int unsigned EN_OFS    = 'h100;
    localparam int unsigned THR_OFS   = 'h180;
    localparam int unsigned CLAIM_OFS = 'h184;

    typedef logic [PRIO_W_DEFAULT-1:0] prio_t;

    // Which register a bus access hits
    typedef enum logic [2:0] {
        REG_NONE,
        REG_PRIO,
        REG_PEND,
        REG_EN,
        REG_THR,
        REG_CLAIM
    } reg_sel_e;

endpackage

// File: rtl/plic_target_ctrl_if.sv
// ---------------------------------------------------------------------------
// plic_target_ctrl_if
// Wishbone B4 classic slave bundle for the PLIC target controller.
//   wb_adr_i  byte address (bits [1:0] ignored by the slave)
//   wb_dat_i  write data
//   wb_sel_i  byte selects (ignored, full-word accesses only)
//   wb_we_i   write enable
//   wb_cyc_i  bus cycle
//   wb_stb_i  strobe
//   wb_dat_o  read data, valid while wb_ack_o is high
//   wb_ack_o  single-cycle acknowledge
// master drives the request side, slave drives data/ack back.
// ---------------------------------------------------------------------------
interface plic_target_ctrl_if #(
    parameter int ADDR_W = plic_pkg::ADDR_W_DEFAULT
) ();

    logic [ADDR_W-1:0] wb_adr_i;
    logic [31:0]       wb_dat_i;
    logic [3:0]        wb_sel_i;
    logic              wb_we_i;
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/plic_gateway.sv
// ---------------------------------------------------------------------------
// plic_gateway
// Per-source interrupt gateway: latches a level line as pending and tracks
// whether the source has been claimed and not yet completed (in flight).
//   clk         system clock
//   reset       asynchronous, active-high reset
//   i_irq       level interrupt line of this source
//   i_claim     this source is claimed on this edge
//   i_complete  a complete for this source's ID is written on this edge
//   o_pending   pending flag
// ---------------------------------------------------------------------------
module plic_gateway (
    input  logic clk,
    input  logic reset,
    input  logic i_irq,
    input  logic i_claim,
    input  logic i_complete,
    output logic o_pending
);

    logic r_pending;
    logic r_inFlight;

    // A claim moves the source from pending to in flight. While in flight
    // the line is masked, so a still-high level line re-pends only after
    // the complete has cleared in_flight (the edge after the complete).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending  <= 1'b0;
            r_inFlight <= 1'b0;
        end else if (i_claim) begin
            r_pending  <= 1'b0;
            r_inFlight <= 1'b1;
        end else begin
            if (i_irq && !r_pending && !r_inFlight) begin
                r_pending <= 1'b1;
            end
            if (i_complete) begin
                r_inFlight <= 1'b0;
            end
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/plic_target_ctrl.sv
// ---------------------------------------------------------------------------
// plic_target_ctrl
// Single-target PLIC: gates the SoC peripheral interrupt lines, arbitrates
// by priority against a threshold and raises the machine external interrupt.
// Firmware programs it and does claim/complete over a Wishbone slave port.
//   clk        system clock
//   reset      asynchronous, active-high reset
//   irq_src_i  level lines, bit k-1 is source ID k
//              (uart, spi_flash, spi2, gpio, i2c, ptc)
//   wb         Wishbone classic slave port (plic_target_ctrl_if.slave)
//   ext_irq_o  machine external interrupt (MEIP), registered
// Register map (byte offsets): 0x000+4*id priority, 0x080 pending (RO),
// 0x100 enable, 0x180 threshold, 0x184 claim (read) / complete (write).
// ---------------------------------------------------------------------------
module plic_target_ctrl
    import plic_pkg::*;
#(
    parameter int N_SRC  = N_SRC_DEFAULT,
    parameter int PRIO_W = PRIO_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   irq_src_i,
    plic_target_ctrl_if.slave  wb,
    output logic               ext_irq_o
);

    localparam int ID_W = $clog2(N_SRC + 1);
    localparam int WA_W = ADDR_W - 2;

    // Word addresses of the fixed registers
    localparam logic [WA_W-1:0] PRIO_FIRST_WA = WA_W'((PRIO_BASE >> 2) + 1);
    localparam logic [WA_W-1:0] PRIO_LAST_WA  = WA_W'((PRIO_BASE >> 2) + N_SRC);
    localparam logic [WA_W-1:0] PEND_WA       = WA_W'(PEND_OFS >> 2);
    localparam logic [WA_W-1:0] EN_WA         = WA_W'(EN_OFS >> 2);
    localparam logic [WA_W-1:0] THR_WA        = WA_W'(THR_OFS >> 2);
    localparam logic [WA_W-1:0] CLAIM_WA      = WA_W'(CLAIM_OFS >> 2);

    logic [WA_W-1:0]   w_wordAdr;
    reg_sel_e          w_sel;
    logic              w_access;
    logic              w_rdEn;
    logic              w_wrEn;
    logic              w_claimRd;
    logic              w_completeWr;
    logic [N_SRC:1]    w_pending;
    logic [ID_W-1:0]   w_candId;
    logic [31:0]       w_rdata;
    logic              w_unusedBits;

    logic [PRIO_W-1:0] r_prio [1:N_SRC];
    logic [N_SRC:1]    r_enable;
    logic [PRIO_W-1:0] r_thr;
    logic              r_ack;
    logic [31:0]       r_datO;
    logic              r_extIrq;

    assign w_wordAdr    = wb.wb_adr_i[ADDR_W-1:2];
    assign w_unusedBits = ^{wb.wb_sel_i, wb.wb_adr_i[1:0]};

    // An access fires only on the edge that raises ack, so a held strobe
    // produces exactly one side effect per acknowledge.
    assign w_access     = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
    assign w_rdEn       = w_access & ~wb.wb_we_i;
    assign w_wrEn       = w_access & wb.wb_we_i;
    assign w_claimRd    = w_rdEn && (w_sel == REG_CLAIM);
    assign w_completeWr = w_wrEn && (w_sel == REG_CLAIM);

    // Address decode; priority slot 0 (ID 0) is reserved and stays unmapped
    always_comb begin
        w_sel = REG_NONE;
        if (w_wordAdr >= PRIO_FIRST_WA && w_wordAdr <= PRIO_LAST_WA) begin
            w_sel = REG_PRIO;
        end else if (w_wordAdr == PEND_WA) begin
            w_sel = REG_PEND;
        end else if (w_wordAdr == EN_WA) begin
            w_sel = REG_EN;
        end else if (w_wordAdr == THR_WA) begin
            w_sel = REG_THR;
        end else if (w_wordAdr == CLAIM_WA) begin
            w_sel = REG_CLAIM;
        end
    end

    // Arbiter: strictly-greater comparison while scanning upward keeps the
    // lowest ID on ties, and seeding with the threshold means only
    // priorities above it can win (priority 0 therefore never wins).
    always_comb begin : arbiter
        logic [PRIO_W-1:0] bestPrio;
        bestPrio = r_thr;
        w_candId = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            if (w_pending[k] && r_enable[k] && (r_prio[k] > bestPrio)) begin
                bestPrio = r_prio[k];
                w_candId = ID_W'(k);
            end
        end
    end

    // Read data mux; unmapped addresses read as zero
    always_comb begin
        w_rdata = '0;
        case (w_sel)
            REG_PRIO: begin
                for (int k = 1; k <= N_SRC; k++) begin
                    if (w_wordAdr == WA_W'((PRIO_BASE >> 2) + k)) begin
                        w_rdata = 32'(r_prio[k]);
                    end
                end
            end
            REG_PEND:  w_rdata = 32'({w_pending, 1'b0});
            REG_EN:    w_rdata = 32'({r_enable, 1'b0});
            REG_THR:   w_rdata = 32'(r_thr);
            REG_CLAIM: w_rdata = 32'(w_candId);
            default:   w_rdata = '0;
        endcase
    end

    // One gateway per source; the claim targets the current candidate and
    // a complete matches only the exact ID written, so ID 0 and
    // out-of-range IDs fall through without effect.
    for (genvar g = 1; g <= N_SRC; g++) begin : gen_gateway
        plic_gateway u_gateway (
            .clk        (clk),
            .reset      (reset),
            .i_irq      (irq_src_i[g-1]),
            .i_claim    (w_claimRd && (w_candId == ID_W'(g))),
            .i_complete (w_completeWr && (wb.wb_dat_i == 32'(g))),
            .o_pending  (w_pending[g])
        );
    end

    // Register file, bus handshake and registered interrupt output.
    // ext_irq_o follows the arbiter one edge late, so threshold/enable
    // writes and claims show up on the edge after the acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= N_SRC; k++) begin
                r_prio[k] <= '0;
            end
            r_enable <= '0;
            r_thr    <= '0;
            r_ack    <= 1'b0;
            r_datO   <= '0;
            r_extIrq <= 1'b0;
        end else begin
            r_ack    <= w_access;
            r_datO   <= w_rdEn ? w_rdata : '0;
            r_extIrq <= (w_candId != '0);
            if (w_wrEn) begin
                case (w_sel)
                    REG_PRIO: begin
                        for (int k = 1; k <= N_SRC; k++) begin
                            if (w_wordAdr == WA_W'((PRIO_BASE >> 2) + k)) begin
                                r_prio[k] <= wb.wb_dat_i[PRIO_W-1:0];
                            end
                        end
                    end
                    REG_EN:  r_enable <= wb.wb_dat_i[N_SRC:1];
                    REG_THR: r_thr    <= wb.wb_dat_i[PRIO_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_datO;
    assign ext_irq_o   = r_extIrq;

endmodule

// File: tb/tb_plic_target_ctrl.sv
// ---------------------------------------------------------------------------
// tb_plic_target_ctrl
// Self-checking bench for plic_target_ctrl: directed scenarios plus a
// randomized claim/complete session checked against a set-based model.
// ---------------------------------------------------------------------------
module tb_plic_target_ctrl;
    import plic_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] irq = '0;
    logic       extIrq;

    int checks = 0;
    int failures = 0;

    // Reference model state: plain sets of IDs and programmed values
    prio_t      mPrio [1:6];
    int         mThr;
    logic [6:1] mEn;
    logic [6:1] mPend;
    logic [6:1] mInfl;

    plic_target_ctrl_if #(.ADDR_W(10)) wbIf ();

    plic_target_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src_i (irq),
        .wb        (wbIf),
        .ext_irq_o (extIrq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Highest priority above threshold wins, lowest ID among equals
    function automatic int modelClaim();
        for (int p = (1 << PRIO_W_DEFAULT) - 1; p > mThr; p--) begin
            for (int id = 1; id <= 6; id++) begin
                if (mPend[id] && mEn[id] && (int'(mPrio[id]) == p)) return id;
            end
        end
        return 0;
    endfunction

    // Bus access; starts and ends on a falling edge, side effect happens on
    // the rising edge right after the request is driven
    task automatic wbAccess(input logic we, input logic [9:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata);
        logic got;
        got = 1'b0;
        rdata = '0;
        if (wbIf.wb_ack_o) @(negedge clk);
        wbIf.wb_adr_i = addr;
        wbIf.wb_dat_i = wdata;
        wbIf.wb_sel_i = 4'hF;
        wbIf.wb_we_i  = we;
        wbIf.wb_cyc_i = 1'b1;
        wbIf.wb_stb_i = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (wbIf.wb_ack_o) begin
                got = 1'b1;
                rdata = wbIf.wb_dat_o;
            end
        end
        wbIf.wb_cyc_i = 1'b0;
        wbIf.wb_stb_i = 1'b0;
        wbIf.wb_we_i  = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL bus_timeout addr=%0h got=no_ack exp=ack", addr);
        end
    endtask

    task automatic wbWrite(input logic [9:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        wbAccess(1'b1, addr, data, dummy);
    endtask

    task automatic wbRead(input logic [9:0] addr, output logic [31:0] data);
        wbAccess(1'b0, addr, 32'd0, data);
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        irq = '0;
        wbIf.wb_cyc_i = 1'b0;
        wbIf.wb_stb_i = 1'b0;
        wbIf.wb_we_i  = 1'b0;
        wbIf.wb_adr_i = '0;
        wbIf.wb_dat_i = '0;
        wbIf.wb_sel_i = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        applyReset();
        checks++;
        if (wbIf.wb_ack_o !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", wbIf.wb_ack_o); end
        checks++;
        if (wbIf.wb_dat_o !== 32'd0) begin failures++; $display("FAIL rst_dat got=%0h exp=0", wbIf.wb_dat_o); end
        checks++;
        if (extIrq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", extIrq); end
        for (int id = 1; id <= 6; id++) begin
            wbRead(10'(4 * id), d);
            checks++;
            if (d !== 32'd0) begin failures++; $display("FAIL rst_prio%0d got=%0h exp=0", id, d); end
        end
        wbRead(10'(PEND_OFS), d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL rst_pend got=%0h exp=0", d); end
        wbRead(10'(EN_OFS), d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL rst_en got=%0h exp=0", d); end
        wbRead(10'(THR_OFS), d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL rst_thr got=%0h exp=0", d); end
        wbRead(10'(CLAIM_OFS), d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL rst_claim got=%0h exp=0", d); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        applyReset();
        wbWrite(10'(4 * 6), 32'd3);
        wbWrite(10'(EN_OFS), 32'h40);
        wbWrite(10'(THR_OFS), 32'd0);
        @(negedge clk);
        irq[5] = 1'b1;
        @(negedge clk);
        checks++;
        if (extIrq !== 1'b0) begin failures++; $display("FAIL prio_lat1 got=%b exp=0", extIrq); end
        @(negedge clk);
        checks++;
        if (extIrq !== 1'b1) begin failures++; $display("FAIL prio_lat2 got=%b exp=1", extIrq); end
        wbRead(10'(CLAIM_OFS), d);
        checks++;
        if (d !== 32'd6) begin failures++; $display("FAIL prio_claim got=%0d exp=6", d); end
        checks++;
        if (extIrq !== 1'b1) begin failures++; $display("FAIL prio_claim_edge got=%b exp=1", extIrq); end
        @(negedge clk);
        checks++;
        if (extIrq !== 1'b0) begin failures++; $display("FAIL prio_after_claim got=%b exp=0", extIrq); end
        irq = '0;
        wbWrite(10'(CLAIM_OFS), 32'd6);
        wbRead(10'(PEND_OFS), d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL prio_pend_end got=%0h exp=0", d); end
    endtask

    task automatic test_tie_break();
        logic [31:0] d;
        applyReset();
        wbWrite(10'(4 * 1), 32'd2);
        wbWrite(10'(4 * 4), 32'd2);
        wbWrite(10'(EN_OFS), 32'h12);
        @(negedge clk);
        irq = 6'b001001;
        @(negedge clk);
        irq = '0;
        repeat (2) @(negedge clk);
        wbRead(10'(CLAIM_OFS), d);
        checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL tie_first got=%0d exp=1", d); end
        wbRead(10'(CLAIM_OFS), d);
        checks++;
        if (d !== 32'd4) begin failures++; $display("FAIL tie_second got=%0d exp=4", d); end
        wbRead(10'(CLAIM_OFS), d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL tie_third got=%0d exp=0", d); end
        @(negedge clk);
        checks++;
        if (extIrq !== 1'b0) begin failures++; $display("FAIL tie_irq got=%b exp=0", extIrq); end
    endtask

    task automatic test_threshold();
        logic [31:0] d;
        applyReset();
        wbWrite(10'(4 * 3), 32'd2);
        wbWrite(10'(EN_OFS), 32'h08);
        wbWrite(10'(THR_OFS), 32'd2);
        @(negedge clk);
        irq = 6'b000100;
        repeat (3) @(negedge clk);
        checks++;
        if (extIrq !== 1'b0) begin failures++; $display("FAIL thr_block got=%b exp=0", extIrq); end
        wbWrite(10'(THR_OFS), 32'd1);
        checks++;
        if (extIrq !== 1'b0) begin failures++; $display("FAIL thr_ack_edge got=%b exp=0", extIrq); end
        @(negedge clk);
        checks++;
        if (extIrq !== 1'b1) begin failures++; $display("FAIL thr_open got=%b exp=1", extIrq); end
        wbRead(10'(CLAIM_OFS), d);
        checks++;
        if (d !== 32'd3) begin failures++; $display("FAIL thr_claim got=%0d exp=3", d); end
        irq = '0;
        wbWrite(10'(CLAIM_OFS), 32'd3);
    endtask

    task automatic test_inflight();
        logic [31:0] d;
        applyReset();
        wbWrite(10'(4 * 1), 32'd1);
        wbWrite(10'(EN_OFS), 32'h02);
        @(negedge clk);
        irq = 6'b000001;
        repeat (2) @(negedge clk);
        wbRead(10'(CLAIM_OFS), d);
        checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL infl_claim got=%0d exp=1", d); end
        wbRead(10'(PEND_OFS), d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL infl_masked got=%0h exp=0", d); end
        wbWrite(10'(CLAIM_OFS), 32'd1);
        checks++;
        if (extIrq !== 1'b0) begin failures++; $display("FAIL infl_cpl_e0 got=%b exp=0", extIrq); end
        @(negedge clk);
        checks++;
        if (extIrq !== 1'b0) begin failures++; $display("FAIL infl_cpl_e1 got=%b exp=0", extIrq); end
        @(negedge clk);
        checks++;
        if (extIrq !== 1'b1) begin failures++; $display("FAIL infl_cpl_e2 got=%b exp=1", extIrq); end
        wbRead(10'(PEND_OFS), d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL infl_repend got=%0h exp=2", d); end
        wbRead(10'(CLAIM_OFS), d);
        checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL infl_reclaim got=%0d exp=1", d); end
        wbWrite(10'(CLAIM_OFS), 32'd5);
        repeat (2) @(negedge clk);
        wbRead(10'(PEND_OFS), d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL infl_cpl5 got=%0h exp=0", d); end
        checks++;
        if (extIrq !== 1'b0) begin failures++; $display("FAIL infl_cpl5_irq got=%b exp=0", extIrq); end
        irq = '0;
        wbWrite(10'(CLAIM_OFS), 32'd1);
    endtask

    task automatic test_edge_cases();
        logic [31:0] d;
        applyReset();
        wbRead(10'h040, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL edge_unmap040 got=%0h exp=0", d); end
        wbRead(10'h1FC, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL edge_unmap1fc got=%0h exp=0", d); end
        wbWrite(10'h000, 32'd7);
        wbRead(10'h000, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL edge_prio0 got=%0h exp=0", d); end
        wbWrite(10'h1F0, 32'hFFFF_FFFF);
        wbRead(10'(EN_OFS), d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL edge_alias_en got=%0h exp=0", d); end
        wbRead(10'(THR_OFS), d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL edge_alias_thr got=%0h exp=0", d); end

        // Strobe held for four cycles: ack on alternate cycles
        repeat (2) @(negedge clk);
        wbIf.wb_adr_i = 10'(THR_OFS);
        wbIf.wb_we_i  = 1'b0;
        wbIf.wb_cyc_i = 1'b1;
        wbIf.wb_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (wbIf.wb_ack_o !== ((i % 2) == 0)) begin
                failures++;
                $display("FAIL edge_held_ack%0d got=%b exp=%b", i + 1, wbIf.wb_ack_o, ((i % 2) == 0));
            end
        end
        wbIf.wb_cyc_i = 1'b0;
        wbIf.wb_stb_i = 1'b0;

        // Claim of source 2 on the same edge source 5 is set
        wbWrite(10'(4 * 2), 32'd2);
        wbWrite(10'(4 * 5), 32'd7);
        wbWrite(10'(EN_OFS), 32'h24);
        @(negedge clk);
        irq = 6'b000010;
        repeat (3) @(negedge clk);
        irq = 6'b010010;
        wbRead(10'(CLAIM_OFS), d);
        checks++;
        if (d !== 32'd2) begin failures++; $display("FAIL edge_same_claim got=%0d exp=2", d); end
        wbRead(10'(PEND_OFS), d);
        checks++;
        if (d !== 32'h20) begin failures++; $display("FAIL edge_same_pend got=%0h exp=20", d); end
        wbRead(10'(CLAIM_OFS), d);
        checks++;
        if (d !== 32'd5) begin failures++; $display("FAIL edge_same_claim5 got=%0d exp=5", d); end
        irq = '0;
        wbWrite(10'(CLAIM_OFS), 32'd2);
        wbWrite(10'(CLAIM_OFS), 32'd5);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        applyReset();
        wbWrite(10'(4 * 6), 32'd1);
        wbWrite(10'(EN_OFS), 32'h40);
        @(negedge clk);
        irq = 6'b100000;
        repeat (3) @(negedge clk);
        checks++;
        if (extIrq !== 1'b1) begin failures++; $display("FAIL rmid_pre_irq got=%b exp=1", extIrq); end
        wbIf.wb_adr_i = 10'(CLAIM_OFS);
        wbIf.wb_we_i  = 1'b0;
        wbIf.wb_cyc_i = 1'b1;
        wbIf.wb_stb_i = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (wbIf.wb_ack_o !== 1'b0) begin failures++; $display("FAIL rmid_ack got=%b exp=0", wbIf.wb_ack_o); end
        checks++;
        if (extIrq !== 1'b0) begin failures++; $display("FAIL rmid_irq got=%b exp=0", extIrq); end
        checks++;
        if (wbIf.wb_dat_o !== 32'd0) begin failures++; $display("FAIL rmid_dat got=%0h exp=0", wbIf.wb_dat_o); end
        repeat (2) @(negedge clk);
        checks++;
        if (wbIf.wb_ack_o !== 1'b0) begin failures++; $display("FAIL rmid_ack_held got=%b exp=0", wbIf.wb_ack_o); end
        wbIf.wb_cyc_i = 1'b0;
        wbIf.wb_stb_i = 1'b0;
        irq = '0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (wbIf.wb_ack_o !== 1'b0) begin failures++; $display("FAIL rmid_post_ack%0d got=%b exp=0", i, wbIf.wb_ack_o); end
        end
        wbRead(10'(PEND_OFS), d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL rmid_pend got=%0h exp=0", d); end
        wbRead(10'(EN_OFS), d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL rmid_en got=%0h exp=0", d); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [5:0]  mask;
        logic [5:0]  keep;
        int          exp;
        for (int it = 0; it < 12; it++) begin
            applyReset();
            mPend = '0;
            mInfl = '0;
            for (int id = 1; id <= 6; id++) begin
                mPrio[id] = prio_t'($urandom_range(0, 7));
                wbWrite(10'(4 * id), 32'(mPrio[id]));
            end
            mEn = 6'($urandom_range(0, 63));
            wbWrite(10'(EN_OFS), {25'($urandom), mEn, 1'($urandom)});
            wbRead(10'(EN_OFS), d);
            checks++;
            if (d !== 32'({mEn, 1'b0})) begin failures++; $display("FAIL rnd_en it=%0d got=%0h exp=%0h", it, d, 32'({mEn, 1'b0})); end
            mThr = $urandom_range(0, 4);
            wbWrite(10'(THR_OFS), 32'(mThr));

            mask = 6'($urandom_range(1, 63));
            @(negedge clk);
            irq = mask;
            repeat (2) @(negedge clk);
            irq = '0;
            repeat (2) @(negedge clk);
            mPend = mask;
            wbRead(10'(PEND_OFS), d);
            checks++;
            if (d !== 32'({mPend, 1'b0})) begin failures++; $display("FAIL rnd_pend it=%0d got=%0h exp=%0h", it, d, 32'({mPend, 1'b0})); end
            checks++;
            if (extIrq !== (modelClaim() != 0)) begin failures++; $display("FAIL rnd_irq it=%0d got=%b exp=%b", it, extIrq, (modelClaim() != 0)); end

            for (int n = 0; n < 7; n++) begin
                exp = modelClaim();
                wbRead(10'(CLAIM_OFS), d);
                checks++;
                if (d !== 32'(exp)) begin failures++; $display("FAIL rnd_claim it=%0d n=%0d got=%0d exp=%0d", it, n, d, exp); end
                if (exp == 0) break;
                mPend[exp] = 1'b0;
                mInfl[exp] = 1'b1;
            end

            // Complete a random subset, plus IDs that must be ignored
            keep = 6'($urandom_range(0, 63));
            wbWrite(10'(CLAIM_OFS), 32'd0);
            wbWrite(10'(CLAIM_OFS), 32'(7 + $urandom_range(0, 100)));
            for (int id = 1; id <= 6; id++) begin
                if (mInfl[id] && !keep[id-1]) begin
                    wbWrite(10'(CLAIM_OFS), 32'(id));
                    mInfl[id] = 1'b0;
                end
            end
            @(negedge clk);
            irq = 6'h3F;
            repeat (2) @(negedge clk);
            irq = '0;
            repeat (2) @(negedge clk);
            mPend = mPend | ~mInfl;
            wbRead(10'(PEND_OFS), d);
            checks++;
            if (d !== 32'({mPend, 1'b0})) begin failures++; $display("FAIL rnd_repend it=%0d got=%0h exp=%0h", it, d, 32'({mPend, 1'b0})); end
            exp = modelClaim();
            wbRead(10'(CLAIM_OFS), d);
            checks++;
            if (d !== 32'(exp)) begin failures++; $display("FAIL rnd_claim2 it=%0d got=%0d exp=%0d", it, d, exp); end
        end
    endtask

    initial begin
        wbIf.wb_adr_i = '0;
        wbIf.wb_dat_i = '0;
        wbIf.wb_sel_i = '0;
        wbIf.wb_we_i  = 1'b0;
        wbIf.wb_cyc_i = 1'b0;
        wbIf.wb_stb_i = 1'b0;
        test_reset();
        test_priority();
        test_tie_break();
        test_threshold();
        test_inflight();
        test_edge_cases();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
